// File: rtl/trackball_pkg.sv
// Shared types for the trackball source arbiter: owner encoding, mouse speed
// settings and the per-axis velocity command handed to the quadrature generator.
package trackball_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_MOUSE = 2'd1,
    OWN_DIG   = 2'd2,
    OWN_ANA   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    SPD_QUARTER = 2'd0,
    SPD_HALF    = 2'd1,
    SPD_X1      = 2'd2,
    SPD_X2      = 2'd3
  } mouse_speed_e;

  typedef struct packed {
    logic       h_dir;
    logic       v_dir;
    logic [7:0] h_mag;
    logic [7:0] v_mag;
  } vel_cmd_t;

endpackage

// File: rtl/trackball_axis_scale.sv
// Combinational single-axis magnitude path: absolute value, then either the
// analog deadzone/shift or the mouse speed scaling with saturation.
module trackball_axis_scale
  import trackball_pkg::*;
#(
  parameter int DEADZONE = 10
) (
  input  logic         [7:0] raw,
  input  logic               neg,
  input  logic               analog,
  input  logic               sens,
  input  mouse_speed_e       speed,
  output logic         [7:0] mag
);

  localparam logic [7:0] DZ = 8'(DEADZONE);

  logic [7:0] a;
  logic [8:0] dbl;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a   = neg ? (~raw + 8'd1) : raw;
    dbl = {a, 1'b0};
    mag = a;
    if (analog) begin
      if (a < DZ)    mag = 8'd0;
      else if (sens) mag = a >> 2;
      else           mag = a >> 1;
    end else begin
      unique case (speed)
        SPD_QUARTER: mag = a >> 2;
        SPD_HALF:    mag = a >> 1;
        SPD_X1:      mag = a;
        SPD_X2:      mag = dbl[8] ? 8'hFF : dbl[7:0];
      endcase
    end
  end

endmodule

// File: rtl/trackball_src_arbiter.sv
// Arbitrates PS/2 mouse, digital and analog joystick into one velocity command
// stream with ownership, idle release and a valid/ready output register.
module trackball_src_arbiter
  import trackball_pkg::*;
#(
  parameter int JOY_DIV     = 60000,
  parameter int ANA_DIV     = 300000,
  parameter int DEADZONE    = 10,
  parameter int IDLE_CYCLES = 6000000,
  parameter int JOY_SPD_LO  = 16,
  parameter int JOY_SPD_HI  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  joystick,
  input  logic [15:0] joystick_analog,
  input  logic        joystick_mode,
  input  logic        joystick_sensitivity,
  input  logic [1:0]  mouse_speed,
  input  logic [24:0] ps2_mouse,
  input  logic        flip,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_h_dir,
  output logic        cmd_v_dir,
  output logic [7:0]  cmd_h_mag,
  output logic [7:0]  cmd_v_mag,
  output logic [1:0]  owner,
  output logic [7:0]  overrun_cnt
);

  localparam int JW = $clog2(JOY_DIV + 1);
  localparam int AW = $clog2(ANA_DIV + 1);
  localparam int TW = $clog2(IDLE_CYCLES + 1);
  localparam logic [JW-1:0] JOY_RELOAD = JW'(JOY_DIV);
  localparam logic [AW-1:0] ANA_RELOAD = AW'(ANA_DIV);
  localparam logic [TW-1:0] TIMEOUT_AT = TW'(IDLE_CYCLES - 1);
  localparam logic [7:0]    SPD_LO     = 8'(JOY_SPD_LO);
  localparam logic [7:0]    SPD_HI     = 8'(JOY_SPD_HI);

  logic          armed_q, tog_q;
  logic [JW-1:0] joy_div_q;
  logic [AW-1:0] ana_div_q;
  logic [TW-1:0] timer_q;
  owner_e        state_q, state_d;
  vel_cmd_t      cmd_q, cmd_d, mouse_cmd, dig_cmd, ana_cmd;
  logic          valid_q;
  logic [7:0]    ovr_q;
  logic          mouse_ev, dig_ev, ana_ev;
  logic          accept, go_idle, timeout, load;
  logic          unused_ps2;

  assign unused_ps2 = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

  // The toggle bit is only compared once the copy has been loaded after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      tog_q   <= ps2_mouse[24];
    end
  end

  assign mouse_ev = armed_q && (ps2_mouse[24] != tog_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_div_q <= JOY_RELOAD;
      ana_div_q <= ANA_RELOAD;
    end else if (!joystick_mode) begin
      joy_div_q <= (joy_div_q == '0) ? JOY_RELOAD : joy_div_q - 1'b1;
    end else begin
      ana_div_q <= (ana_div_q == '0) ? ANA_RELOAD : ana_div_q - 1'b1;
    end
  end

  assign dig_ev = !joystick_mode && (joy_div_q == '0) && (joystick != 4'd0);
  assign ana_ev =  joystick_mode && (ana_div_q == '0) && (joystick_analog != 16'd0);

  trackball_axis_scale #(.DEADZONE(DEADZONE)) u_mouse_x (
    .raw(ps2_mouse[15:8]), .neg(ps2_mouse[4]), .analog(1'b0), .sens(1'b0),
    .speed(mouse_speed_e'(mouse_speed)), .mag(mouse_cmd.h_mag)
  );
  trackball_axis_scale #(.DEADZONE(DEADZONE)) u_mouse_y (
    .raw(ps2_mouse[23:16]), .neg(ps2_mouse[5]), .analog(1'b0), .sens(1'b0),
    .speed(mouse_speed_e'(mouse_speed)), .mag(mouse_cmd.v_mag)
  );
  trackball_axis_scale #(.DEADZONE(DEADZONE)) u_ana_x (
    .raw(joystick_analog[7:0]), .neg(joystick_analog[7]), .analog(1'b1),
    .sens(joystick_sensitivity), .speed(SPD_X1), .mag(ana_cmd.h_mag)
  );
  trackball_axis_scale #(.DEADZONE(DEADZONE)) u_ana_y (
    .raw(joystick_analog[15:8]), .neg(joystick_analog[15]), .analog(1'b1),
    .sens(joystick_sensitivity), .speed(SPD_X1), .mag(ana_cmd.v_mag)
  );

  assign mouse_cmd.h_dir = ps2_mouse[4];
  assign mouse_cmd.v_dir = ps2_mouse[5];
  assign ana_cmd.h_dir   = joystick_analog[7];
  assign ana_cmd.v_dir   = ~joystick_analog[15];

  // Left beats right and up beats down when both bits of an axis are set.
  assign dig_cmd.h_dir = joystick[1];
  assign dig_cmd.v_dir = joystick[2] & ~joystick[3];
  assign dig_cmd.h_mag = (|joystick[1:0]) ? (joystick_sensitivity ? SPD_HI : SPD_LO) : 8'd0;
  assign dig_cmd.v_mag = (|joystick[3:2]) ? (joystick_sensitivity ? SPD_HI : SPD_LO) : 8'd0;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    go_idle = 1'b0;
    timeout = 1'b0;
    cmd_d   = mouse_cmd;
    if (mouse_ev) begin
      state_d = OWN_MOUSE;
      accept  = 1'b1;
    end else begin
      unique case (state_q)
        OWN_NONE: begin
          if (dig_ev) begin
            state_d = OWN_DIG;
            accept  = 1'b1;
            cmd_d   = dig_cmd;
          end else if (ana_ev) begin
            state_d = OWN_ANA;
            accept  = 1'b1;
            cmd_d   = ana_cmd;
          end
        end
        OWN_MOUSE: ;
        OWN_DIG: begin
          if (joystick_mode) go_idle = 1'b1;
          else if (dig_ev) begin
            accept = 1'b1;
            cmd_d  = dig_cmd;
          end
        end
        OWN_ANA: begin
          if (!joystick_mode) go_idle = 1'b1;
          else if (ana_ev) begin
            accept = 1'b1;
            cmd_d  = ana_cmd;
          end
        end
      endcase
    end
    if (!accept && !go_idle && state_q != OWN_NONE && timer_q == TIMEOUT_AT) timeout = 1'b1;
    if (go_idle || timeout) state_d = OWN_NONE;
    // Accepted commands are flipped on the way in; the idle stop keeps the held directions.
    if (timeout) cmd_d = '{h_dir: cmd_q.h_dir, v_dir: cmd_q.v_dir, h_mag: 8'd0, v_mag: 8'd0};
    else begin
      cmd_d.h_dir = cmd_d.h_dir ^ flip;
      cmd_d.v_dir = cmd_d.v_dir ^ flip;
    end
  end

  assign load = accept || timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OWN_NONE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept || go_idle || timeout) timer_q <= '0;
      else if (state_q != OWN_NONE)     timer_q <= timer_q + 1'b1;
    end
  end

  // A load over an unconsumed command counts as an overrun unless it coincides with the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 8'd0;
    end else if (load) begin
      cmd_q   <= cmd_d;
      valid_q <= 1'b1;
      if (valid_q && !cmd_ready && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end else if (valid_q && cmd_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_h_dir   = cmd_q.h_dir;
  assign cmd_v_dir   = cmd_q.v_dir;
  assign cmd_h_mag   = cmd_q.h_mag;
  assign cmd_v_mag   = cmd_q.v_mag;
  assign owner       = state_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_trackball_src_arbiter.sv
// Directed and randomized bench for trackball_src_arbiter against a cycle-level
// reference model built from the source/ownership/handshake rules.
module tb_trackball_src_arbiter;

  localparam int JOY_DIV     = 8;
  localparam int ANA_DIV     = 10;
  localparam int DEADZONE    = 10;
  localparam int IDLE_CYCLES = 20;
  localparam int JOY_SPD_LO  = 16;
  localparam int JOY_SPD_HI  = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  joystick;
  logic [15:0] joystick_analog;
  logic        joystick_mode, joystick_sensitivity, flip, cmd_ready;
  logic [1:0]  mouse_speed;
  logic [24:0] ps2_mouse;
  logic        cmd_valid, cmd_h_dir, cmd_v_dir;
  logic [7:0]  cmd_h_mag, cmd_v_mag, overrun_cnt;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  trackball_src_arbiter #(
    .JOY_DIV(JOY_DIV), .ANA_DIV(ANA_DIV), .DEADZONE(DEADZONE),
    .IDLE_CYCLES(IDLE_CYCLES), .JOY_SPD_LO(JOY_SPD_LO), .JOY_SPD_HI(JOY_SPD_HI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .joystick(joystick), .joystick_analog(joystick_analog),
    .joystick_mode(joystick_mode), .joystick_sensitivity(joystick_sensitivity),
    .mouse_speed(mouse_speed), .ps2_mouse(ps2_mouse), .flip(flip),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_h_dir(cmd_h_dir),
    .cmd_v_dir(cmd_v_dir), .cmd_h_mag(cmd_h_mag), .cmd_v_mag(cmd_v_mag),
    .owner(owner), .overrun_cnt(overrun_cnt)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  bit m_armed, m_copy, m_valid, m_hd, m_vd;
  int m_jdiv, m_adiv, m_own, m_timer, m_hm, m_vm, m_ovr;
  bit found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mouse_mag(input int d, input bit s, input int spd);
    int a;
    a = s ? ((256 - d) % 256) : d;
    case (spd)
      0:       return a / 4;
      1:       return a / 2;
      2:       return a;
      default: return (2 * a > 255) ? 255 : 2 * a;
    endcase
  endfunction

  function automatic int ana_mag(input int raw, input bit sens);
    int v, a;
    v = (raw >= 128) ? raw - 256 : raw;
    a = (v < 0) ? -v : v;
    if (a < DEADZONE) return 0;
    return sens ? a / 4 : a / 2;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_copy = 0; m_jdiv = JOY_DIV; m_adiv = ANA_DIV;
    m_own = 0; m_timer = 0; m_valid = 0; m_hd = 0; m_vd = 0;
    m_hm = 0; m_vm = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit mev, jev, aev, tmo, leave, nhd, nvd;
    int src, nh, nv, spd;
    mev = m_armed && (ps2_mouse[24] != m_copy);
    jev = !joystick_mode && m_jdiv == 0 && joystick != 0;
    aev = joystick_mode && m_adiv == 0 && joystick_analog != 0;
    src = 0; leave = 0;
    if (mev) src = 1;
    else case (m_own)
      0: if (jev) src = 2; else if (aev) src = 3;
      2: if (joystick_mode) leave = 1; else if (jev) src = 2;
      3: if (!joystick_mode) leave = 1; else if (aev) src = 3;
      default: ;
    endcase
    tmo = (src == 0) && !leave && m_own != 0 && m_timer == IDLE_CYCLES - 1;
    spd = joystick_sensitivity ? JOY_SPD_HI : JOY_SPD_LO;
    nh = 0; nv = 0; nhd = 0; nvd = 0;
    case (src)
      1: begin
        nh = mouse_mag(ps2_mouse[15:8], ps2_mouse[4], mouse_speed);
        nv = mouse_mag(ps2_mouse[23:16], ps2_mouse[5], mouse_speed);
        nhd = ps2_mouse[4]; nvd = ps2_mouse[5];
      end
      2: begin
        nh = (joystick[1] || joystick[0]) ? spd : 0;
        nv = (joystick[3] || joystick[2]) ? spd : 0;
        nhd = joystick[1]; nvd = joystick[2] && !joystick[3];
      end
      3: begin
        nh = ana_mag(joystick_analog[7:0], joystick_sensitivity);
        nv = ana_mag(joystick_analog[15:8], joystick_sensitivity);
        nhd = joystick_analog[7]; nvd = !joystick_analog[15];
      end
      default: ;
    endcase
    if (src != 0 || tmo) begin
      if (m_valid && !cmd_ready && m_ovr < 255) m_ovr++;
      m_valid = 1;
      m_hm = nh; m_vm = nv;
      if (src != 0) begin m_hd = nhd ^ flip; m_vd = nvd ^ flip; end
    end else if (m_valid && cmd_ready) m_valid = 0;
    if (src != 0) begin m_own = src; m_timer = 0; end
    else if (leave || tmo) begin m_own = 0; m_timer = 0; end
    else if (m_own != 0) m_timer++;
    if (!joystick_mode) m_jdiv = (m_jdiv == 0) ? JOY_DIV : m_jdiv - 1;
    else                m_adiv = (m_adiv == 0) ? ANA_DIV : m_adiv - 1;
    m_armed = 1; m_copy = ps2_mouse[24];
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("valid", cmd_valid, m_valid);
    check("h_dir", cmd_h_dir, m_hd);
    check("v_dir", cmd_v_dir, m_vd);
    check("h_mag", cmd_h_mag, m_hm);
    check("v_mag", cmd_v_mag, m_vm);
    check("owner", owner, m_own);
    check("overrun", overrun_cnt, m_ovr);
  endtask

  task automatic mouse_event(input logic [7:0] dx, input logic [7:0] dy, input logic xs, input logic ys);
    ps2_mouse = {~ps2_mouse[24], dy, dx, 2'b00, ys, xs, 4'b0000};
  endtask

  initial begin
    reset_n = 0; joystick = 0; joystick_analog = 0; joystick_mode = 0;
    joystick_sensitivity = 0; mouse_speed = 2; ps2_mouse = 0; flip = 0; cmd_ready = 1;
    model_reset();
    #2;
    check("rst_valid", cmd_valid, 0);
    check("rst_hmag", cmd_h_mag, 0);
    check("rst_owner", owner, 0);
    check("rst_ovr", overrun_cnt, 0);
    #10 reset_n = 1;
    cycle(); cycle();

    // Mouse event: one-cycle latency, then x2 saturation
    mouse_event(8'h10, 8'h00, 0, 0);
    cycle();
    check("m_valid", cmd_valid, 1);
    check("m_hmag", cmd_h_mag, 16);
    check("m_hdir", cmd_h_dir, 0);
    check("m_owner", owner, 1);
    mouse_speed = 3;
    mouse_event(8'h90, 8'h00, 0, 0);
    cycle();
    check("m_sat", cmd_h_mag, 255);

    // Idle release 20 cycles after the last mouse event
    repeat (IDLE_CYCLES - 1) cycle();
    check("to_owner_before", owner, 1);
    cycle();
    check("to_owner", owner, 0);
    check("to_valid", cmd_valid, 1);
    check("to_hmag", cmd_h_mag, 0);
    check("to_vmag", cmd_v_mag, 0);

    // Digital joystick, both H bits set: left wins
    joystick_sensitivity = 1; joystick = 4'b0011;
    found = 0;
    for (int i = 0; i < 2 * JOY_DIV + 4 && !found; i++) begin
      cycle();
      if (owner == 2) found = 1;
    end
    check("dig_owner", owner, 2);
    check("dig_hdir", cmd_h_dir, 1);
    check("dig_hmag", cmd_h_mag, 32);
    check("dig_vmag", cmd_v_mag, 0);

    // Preemption by mouse; held joystick samples are then discarded
    cycle();
    cmd_ready = 0; mouse_speed = 2;
    mouse_event(8'h20, 8'h00, 0, 0);
    cycle();
    check("pre_owner", owner, 1);
    repeat (12) cycle();
    check("pre_owner_hold", owner, 1);
    check("pre_ovr", overrun_cnt, 0);
    check("pre_hmag", cmd_h_mag, 32);
    joystick = 0;

    // Backpressure: three events, two overruns, latest wins
    cmd_ready = 1; cycle();
    cmd_ready = 0;
    mouse_event(8'd1, 8'd0, 0, 0); cycle();
    mouse_event(8'd2, 8'd0, 0, 0); cycle();
    mouse_event(8'd3, 8'd0, 0, 0); cycle();
    check("bp_ovr", overrun_cnt, 2);
    check("bp_hmag", cmd_h_mag, 3);
    check("bp_valid", cmd_valid, 1);
    cmd_ready = 1; cycle();
    check("bp_drop", cmd_valid, 0);
    // Handshake coinciding with a new event keeps valid high, no overrun
    cmd_ready = 0; mouse_event(8'd4, 8'd0, 0, 0); cycle();
    cmd_ready = 1; mouse_event(8'd5, 8'd0, 0, 0); cycle();
    check("hs_valid", cmd_valid, 1);
    check("hs_hmag", cmd_h_mag, 5);
    check("hs_ovr", overrun_cnt, 2);
    cycle();
    check("hs_drop", cmd_valid, 0);

    // Analog: deadzone, then -32 and -128
    found = 0;
    for (int i = 0; i < IDLE_CYCLES + 4 && !found; i++) begin
      cycle();
      if (owner == 0) found = 1;
    end
    check("ana_idle", owner, 0);
    joystick_mode = 1; joystick_sensitivity = 0; joystick_analog = 16'h0005;
    found = 0;
    for (int i = 0; i < ANA_DIV + 4 && !found; i++) begin
      cycle();
      if (owner == 3) found = 1;
    end
    check("ana_owner", owner, 3);
    check("ana_dz", cmd_h_mag, 0);
    cycle();
    joystick_analog = 16'h80E0;
    found = 0;
    for (int i = 0; i < ANA_DIV + 4 && !found; i++) begin
      cycle();
      if (cmd_valid) found = 1;
    end
    check("ana_hmag", cmd_h_mag, 16);
    check("ana_hdir", cmd_h_dir, 1);
    check("ana_vmag", cmd_v_mag, 64);
    check("ana_vdir", cmd_v_dir, 0);
    joystick_mode = 0; cycle();
    check("mode_leave", owner, 0);

    // Overrun counter saturates
    cmd_ready = 0;
    for (int i = 0; i < 260; i++) begin
      mouse_event(8'(i), 8'(i), 0, 1);
      cycle();
    end
    check("ovr_sat", overrun_cnt, 255);
    cmd_ready = 1; cycle(); cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) ps2_mouse = {~ps2_mouse[24], 24'($urandom)};
      if ($urandom_range(0, 5) == 0) joystick = 4'($urandom);
      if ($urandom_range(0, 5) == 0) joystick_analog = 16'($urandom);
      if ($urandom_range(0, 39) == 0) joystick_mode = ~joystick_mode;
      if ($urandom_range(0, 19) == 0) joystick_sensitivity = ~joystick_sensitivity;
      if ($urandom_range(0, 19) == 0) flip = ~flip;
      if ($urandom_range(0, 9) == 0) mouse_speed = 2'($urandom);
      cmd_ready = 1'($urandom);
      cycle();
    end

    // Asynchronous reset with a command pending
    cmd_ready = 0;
    mouse_event(8'h44, 8'h22, 1, 0);
    cycle();
    check("ar_pending", cmd_valid, 1);
    reset_n = 0;
    #1;
    model_reset();
    check("ar_valid", cmd_valid, 0);
    check("ar_hmag", cmd_h_mag, 0);
    check("ar_vmag", cmd_v_mag, 0);
    check("ar_hdir", cmd_h_dir, 0);
    check("ar_owner", owner, 0);
    check("ar_ovr", overrun_cnt, 0);
    #2 reset_n = 1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/trackball_src_arbiter.md
Name: trackball_src_arbiter

Overview:
- Arbitrates three motion sources into one per-axis velocity command stream for the trackball quadrature emulator: PS/2 mouse, digital joystick and analog joystick.
- Grants ownership to one source at a time, paces joystick sampling, and applies deadzone, scaling and flip.
- Delivers commands over a valid/ready handshake, so the quadrature clock generator only consumes settled commands.

Parameters:
- JOY_DIV, 60000: clk cycles between digital joystick samples.
- ANA_DIV, 300000: clk cycles between analog joystick samples.
- DEADZONE, 10: analog magnitudes below this become 0.
- IDLE_CYCLES, 6000000: cycles without an owner event before ownership is released.
- JOY_SPD_LO, 16: digital magnitude when sensitivity=0.
- JOY_SPD_HI, 32: digital magnitude when sensitivity=1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- joystick  in  4  {up,down,left,right}, bit0=right
- joystick_analog  in  16  [15:8]=Y, [7:0]=X, signed two's complement
- joystick_mode  in  1  0=digital, 1=analog
- joystick_sensitivity  in  1  selects joystick scaling
- mouse_speed  in  2  0=x1/4, 1=x1/2, 2=x1, 3=x2
- ps2_mouse  in  25  [24]=event toggle, [23:16]=dY, [15:8]=dX, [5]=Ysign, [4]=Xsign
- flip  in  1  invert both directions
- cmd_valid  out  1  command pending
- cmd_ready  in  1  consumer accepts
- cmd_h_dir  out  1  horizontal direction
- cmd_v_dir  out  1  vertical direction
- cmd_h_mag  out  8  horizontal magnitude
- cmd_v_mag  out  8  vertical magnitude
- owner  out  2  0=none, 1=mouse, 2=digital, 3=analog
- overrun_cnt  out  8  saturating count of overwritten pending commands

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, both dividers loaded with their maximum, idle counter 0, mouse edge detector disarmed.
- Mouse event:
  - Defined as ps2_mouse[24] differing from its registered copy.
  - The first cycle after reset only loads the copy and arms the detector; no event is generated.
- Mouse magnitude:
  - mag = sign ? (-d)[7:0] : d.
  - Scale by mouse_speed; the x2 setting saturates at 255.
  - dir = sign bit.
- Digital joystick sample:
  - Divider counts down only while joystick_mode=0; a sample is taken at 0, then the divider reloads JOY_DIV.
  - An event requires joystick!=0.
  - H axis: right gives h_dir=0, left gives h_dir=1; left wins if both are set.
  - V axis: down gives v_dir=1, up gives v_dir=0; up wins if both are set.
  - Active axis mag = JOY_SPD_HI when sensitivity=1, else JOY_SPD_LO. Inactive axis mag = 0.
- Analog sample:
  - Divider counts down only while joystick_mode=1; reload value is ANA_DIV.
  - An event requires joystick_analog!=0.
  - Per axis: a = |v| as 8 bits (-128 gives 128). mag = 0 if a<DEADZONE, else a>>(sens?2:1).
  - h_dir = X[7]; v_dir = ~Y[7].
- FSM states: IDLE, MOUSE, DIG, ANA.
  - IDLE goes to whichever source produces an event; a mouse event wins a same-cycle tie.
  - A mouse event in DIG or ANA preempts immediately and moves to MOUSE.
  - Joystick events while MOUSE owns are discarded.
  - A joystick_mode change moves DIG or ANA to IDLE the next cycle.
  - owner = encoded state.
- Idle timer:
  - Cleared on every accepted owner event.
  - Increments otherwise; at IDLE_CYCLES it moves to IDLE, clears the timer, and emits a zero command (mags 0, dirs unchanged).
- Command register:
  - An accepted event loads dirs (XORed with flip) and mags, and sets cmd_valid the next cycle (1-cycle latency).
  - While cmd_valid=1 and cmd_ready=0, outputs hold stable.
  - A new event in that condition overwrites the command (latest wins) and increments overrun_cnt, saturating at 255.
  - Transfer occurs when cmd_valid and cmd_ready are both 1. cmd_valid drops the next cycle unless a new event arrives in the same cycle; in that case the new command is loaded with valid still 1 and overrun is not counted.
- Asynchronous reset mid-handshake drops the pending command; no partial state survives.

Decomposition:
- Shared package trackball_pkg holds:
  - the owner encoding (OWN_NONE/MOUSE/DIG/ANA);
  - the mouse_speed encodings;
  - a velocity command struct {h_dir, v_dir, h_mag, v_mag}.
- One sub-module, trackball_axis_scale: combinational per-axis abs, deadzone and shift/saturate. Instanced for X and Y, analog and mouse paths.

Test Plan:
- Mouse event:
  - Stimulus: toggle ps2_mouse[24], dX=0x10, Xsign=0, mouse_speed=2, flip=0.
  - Required response: one cycle later cmd_valid=1, h_mag=16, h_dir=0, owner=1.
  - Also: with mouse_speed=3 and dX=0x90, h_mag=255.
- Digital joystick:
  - Stimulus: JOY_DIV=8, mode=0, joystick=4'b0011, sens=1.
  - Required response: at the sample point, h_dir=1, h_mag=32, v_mag=0, owner=2.
- Analog deadzone:
  - X=0x05: h_mag=0.
  - X=0xE0 with sens=0: h_mag=16, h_dir=1.
  - Y=0x80: v_mag=64, v_dir=0.
- Preemption:
  - Stimulus: owner=2, then a mouse event.
  - Required response: owner=1 next cycle. A following joystick sample is ignored and overrun_cnt stays unchanged.
- Backpressure:
  - Stimulus: hold cmd_ready=0 across 3 mouse events, then raise cmd_ready.
  - Required response: overrun_cnt=2, and the final command transfers; cmd_valid drops 1 cycle after the handshake.
- Timeout:
  - Stimulus: IDLE_CYCLES=20 after a mouse event, with no further input.
  - Required response: 20 cycles later owner=0 and a zero-magnitude command is issued.
  - Also: reset_n asserted mid-pending yields all outputs 0 immediately.
